// File: rtl/axi_responder_pkg.sv
// Shared types and AXI encodings for the BRAM-backed AXI4 responder.
package axi_responder_pkg;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/t_AXI4.sv
// AXI4 bundle between a NAP master and a memory-mapped responder.
interface t_AXI4;
    import axi_responder_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_responder_ram.sv
// Simple dual-port 256-bit RAM, byte-enabled write, registered read-first port.
module axi_responder_ram
    import axi_responder_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [STRB_W-1:0] be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (re)
            q <= mem[raddr];
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (be[i])
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_bram_responder.sv
// AXI4 slave fronting a BRAM: independent write and read FSMs, INCR only.
module axi_bram_responder
    import axi_responder_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int ADDR_LSB = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    t_AXI4.slave        nap,
    output logic [31:0] o_wr_count,
    output logic [31:0] o_rd_count,
    output logic        o_error
);

    localparam int AW = $clog2(DEPTH);

    wr_state_t         wr_state, wr_next;
    logic [ID_W-1:0]   wr_id;
    logic [AW-1:0]     wr_idx;
    logic [7:0]        wr_len, wr_beat;
    logic              wr_incr, wr_err, wr_last;
    logic              aw_hs, w_hs, b_hs;

    rd_state_t         rd_state, rd_next;
    logic [ID_W-1:0]   rd_id;
    logic [AW-1:0]     rd_idx;
    logic [7:0]        rd_len, rd_beat;
    logic              rd_incr, rd_last, rd_en;
    logic              ar_hs, r_hs;
    logic [DATA_W-1:0] ram_q;

    assign aw_hs   = nap.awvalid & nap.awready;
    assign w_hs    = nap.wvalid & nap.wready;
    assign b_hs    = nap.bvalid & nap.bready;
    assign wr_last = (wr_beat == wr_len);
    assign nap.bid   = wr_id;
    assign nap.bresp = wr_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            wr_state <= WR_IDLE;
        else
            wr_state <= wr_next;
    end

    always_comb begin
        wr_next     = wr_state;
        nap.awready = 1'b0;
        nap.wready  = 1'b0;
        nap.bvalid  = 1'b0;
        unique case (wr_state)
            WR_IDLE: begin
                nap.awready = 1'b1;
                if (nap.awvalid)
                    wr_next = WR_DATA;
            end
            WR_DATA: begin
                nap.wready = 1'b1;
                if (nap.wvalid && wr_last)
                    wr_next = WR_RESP;
            end
            WR_RESP: begin
                nap.bvalid = 1'b1;
                if (nap.bready)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_id   <= '0;
            wr_idx  <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_incr <= 1'b0;
            wr_err  <= 1'b0;
        end else if (aw_hs) begin
            wr_id   <= nap.awid;
            wr_idx  <= nap.awaddr[ADDR_LSB +: AW];
            wr_len  <= nap.awlen;
            wr_beat <= '0;
            wr_incr <= (nap.awburst == BURST_INCR);
            wr_err  <= (nap.awburst != BURST_INCR);
        end else if (w_hs) begin
            wr_idx  <= wr_idx + 1'b1;
            wr_beat <= wr_beat + 1'b1;
            // Early or missing wlast poisons the whole burst response.
            if (nap.wlast != wr_last)
                wr_err <= 1'b1;
        end
    end

    assign ar_hs     = nap.arvalid & nap.arready;
    assign r_hs      = nap.rvalid & nap.rready;
    assign rd_last   = (rd_beat == rd_len);
    assign nap.rid   = rd_id;
    assign nap.rdata = ram_q;
    assign nap.rlast = rd_last;
    assign nap.rresp = rd_incr ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            rd_state <= RD_IDLE;
        else
            rd_state <= rd_next;
    end

    always_comb begin
        rd_next     = rd_state;
        nap.arready = 1'b0;
        nap.rvalid  = 1'b0;
        rd_en       = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                nap.arready = 1'b1;
                if (nap.arvalid)
                    rd_next = RD_FETCH;
            end
            RD_FETCH: begin
                rd_en   = 1'b1;
                rd_next = RD_DATA;
            end
            RD_DATA: begin
                nap.rvalid = 1'b1;
                if (nap.rready)
                    rd_next = rd_last ? RD_IDLE : RD_FETCH;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_id   <= '0;
            rd_idx  <= '0;
            rd_len  <= '0;
            rd_beat <= '0;
            rd_incr <= 1'b0;
        end else if (ar_hs) begin
            rd_id   <= nap.arid;
            rd_idx  <= nap.araddr[ADDR_LSB +: AW];
            rd_len  <= nap.arlen;
            rd_beat <= '0;
            rd_incr <= (nap.arburst == BURST_INCR);
        end else if (r_hs && !rd_last) begin
            rd_idx  <= rd_idx + 1'b1;
            rd_beat <= rd_beat + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wr_count <= '0;
            o_rd_count <= '0;
            o_error    <= 1'b0;
        end else begin
            if (b_hs) begin
                o_wr_count <= o_wr_count + 1'b1;
                if (nap.bresp == RESP_SLVERR)
                    o_error <= 1'b1;
            end
            if (r_hs) begin
                if (rd_last)
                    o_rd_count <= o_rd_count + 1'b1;
                if (nap.rresp == RESP_SLVERR)
                    o_error <= 1'b1;
            end
        end
    end

    axi_responder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (w_hs & wr_incr),
        .waddr (wr_idx),
        .be    (nap.wstrb),
        .wdata (nap.wdata),
        .re    (rd_en),
        .raddr (rd_idx),
        .q     (ram_q)
    );

endmodule
